// File: rtl/time_report_tx.sv
// Latches a finished cycle-count duration on capture and streams it LSB-first as bytes over valid/ready.
// Optional framing (header byte + XOR checksum) is enabled by defining TIME_REPORT_HEADER_EN.
module time_report_tx #(
    parameter int TIME_W = 26
`ifdef TIME_REPORT_HEADER_EN
    , parameter logic [7:0] HEADER_BYTE = 8'hA5
`endif
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              capture,
    input  logic [TIME_W-1:0] timeDuration,
    output logic [7:0]        txData,
    output logic              txValid,
    input  logic              txReady,
    output logic              busy,
    output logic              done
);

    localparam int NBYTES  = (TIME_W + 7) / 8;
    localparam int SHIFT_W = NBYTES * 8;
`ifdef TIME_REPORT_HEADER_EN
    localparam int FRAME_BYTES = NBYTES + 2;
`else
    localparam int FRAME_BYTES = NBYTES;
`endif
    localparam int IDX_W = $clog2(FRAME_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [SHIFT_W-1:0] shiftReg;
    logic [IDX_W-1:0]   byteIdx;
    logic               fire;
    logic               lastByte;
    logic               dataByte;
`ifdef TIME_REPORT_HEADER_EN
    logic [7:0]         checksum;
`endif

    assign fire     = (state == SEND) && txReady;
    assign lastByte = (byteIdx == IDX_W'(FRAME_BYTES - 1));
`ifdef TIME_REPORT_HEADER_EN
    // Header and checksum slots do not consume the shift register.
    assign dataByte = (byteIdx != '0) && !lastByte;
`else
    assign dataByte = 1'b1;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (capture) nextState = SEND;
            SEND:    if (fire && lastByte) nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // NOTE: the shift register is small and explicitly reset, so a mid-frame reset leaves no stale data.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            shiftReg <= '0;
            byteIdx  <= '0;
`ifdef TIME_REPORT_HEADER_EN
            checksum <= '0;
`endif
        end else if ((state == IDLE) && capture) begin
            shiftReg <= SHIFT_W'(timeDuration);
            byteIdx  <= '0;
`ifdef TIME_REPORT_HEADER_EN
            checksum <= '0;
`endif
        end else if (fire) begin
            byteIdx <= lastByte ? '0 : byteIdx + IDX_W'(1);
            if (dataByte) begin
                shiftReg <= shiftReg >> 8;
`ifdef TIME_REPORT_HEADER_EN
                checksum <= checksum ^ shiftReg[7:0];
`endif
            end
        end
    end

    always_comb begin
        txValid = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        txData  = 8'h00;
        case (state)
            SEND: begin
                txValid = 1'b1;
                busy    = 1'b1;
                txData  = shiftReg[7:0];
`ifdef TIME_REPORT_HEADER_EN
                if (byteIdx == '0) begin
                    txData = HEADER_BYTE;
                end else if (lastByte) begin
                    txData = checksum;
                end
`endif
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule
